// File: rtl/ocp_master_arb2.sv
// rtl/ocp_master_arb2.sv - two-master round-robin arbiter for the OCP-style register bus
module ocp_master_arb2 #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    m0_MCmd,
  input  logic [AW-1:0] m0_MAddr,
  input  logic [DW-1:0] m0_MData,
  output logic          m0_SCmdAccept,
  output logic [DW-1:0] m0_SData,
  output logic [1:0]    m0_SResp,
  input  logic [2:0]    m1_MCmd,
  input  logic [AW-1:0] m1_MAddr,
  input  logic [DW-1:0] m1_MData,
  output logic          m1_SCmdAccept,
  output logic [DW-1:0] m1_SData,
  output logic [1:0]    m1_SResp,
  output logic [2:0]    s_MCmd,
  output logic [AW-1:0] s_MAddr,
  output logic [DW-1:0] s_MData,
  input  logic          s_SCmdAccept,
  input  logic [DW-1:0] s_SData,
  input  logic [1:0]    s_SResp,
  output logic [1:0]    grant
);

  localparam logic [2:0] CMD_WR = 3'b001;
  localparam logic [2:0] CMD_RD = 3'b010;
  localparam int CW = (RESP_TIMEOUT < 1) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_next;
  logic          last_grant;   // 1 = m1 was granted last
  logic          resp_valid;
  logic          resp_owner;   // 1 = m1 owns the outstanding response
  logic [CW-1:0] cnt;

  logic req0, req1, pick1, load, accept, timeout_fire, resp_seen;
  logic route0, route1;

  assign req0  = (m0_MCmd == CMD_WR) || (m0_MCmd == CMD_RD);
  assign req1  = (m1_MCmd == CMD_WR) || (m1_MCmd == CMD_RD);
  assign pick1 = req1 && (!req0 || !last_grant);

  assign accept       = (state == S_ISSUE) && s_SCmdAccept;
  assign resp_seen    = (s_SResp != 2'b00);
  assign timeout_fire = (RESP_TIMEOUT != 0) && (state == S_WAIT) && !resp_seen && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          state_next = S_ISSUE;
          load       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (s_SCmdAccept) state_next = (s_MCmd == CMD_RD) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (resp_seen || timeout_fire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_MCmd     <= 3'b000;
      s_MAddr    <= '0;
      s_MData    <= '0;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      cnt        <= '0;
    end else begin
      if (load) begin
        s_MCmd     <= pick1 ? m1_MCmd  : m0_MCmd;
        s_MAddr    <= pick1 ? m1_MAddr : m0_MAddr;
        s_MData    <= pick1 ? m1_MData : m0_MData;
        grant      <= pick1 ? 2'b10 : 2'b01;
        last_grant <= pick1;
      end
      // A fresh accept claims the response slot ahead of any stray response this cycle
      if (accept) begin
        s_MCmd     <= 3'b000;
        resp_owner <= grant[1];
        resp_valid <= 1'b1;
        cnt        <= '0;
        if (s_MCmd != CMD_RD) grant <= 2'b00;
      end else if (resp_valid && (resp_seen || timeout_fire)) begin
        resp_valid <= 1'b0;
      end
      if (state == S_WAIT) begin
        if (resp_seen || timeout_fire) grant <= 2'b00;
        else if (cnt != '1)            cnt   <= cnt + 1'b1;
      end
    end
  end

  assign route0 = reset_n && resp_valid && !resp_owner;
  assign route1 = reset_n && resp_valid &&  resp_owner;

  assign m0_SCmdAccept = reset_n && accept && grant[0];
  assign m1_SCmdAccept = reset_n && accept && grant[1];

  assign m0_SResp = route0 ? (timeout_fire ? 2'b11 : s_SResp) : 2'b00;
  assign m1_SResp = route1 ? (timeout_fire ? 2'b11 : s_SResp) : 2'b00;
  assign m0_SData = route0 ? (timeout_fire ? DW'(8'hED) : s_SData) : '0;
  assign m1_SData = route1 ? (timeout_fire ? DW'(8'hED) : s_SData) : '0;

endmodule

// File: tb/tb_ocp_master_arb2.sv
// tb/tb_ocp_master_arb2.sv - directed self-checking bench for ocp_master_arb2
module tb_ocp_master_arb2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] m0_MCmd, m1_MCmd;
  logic [7:0] m0_MAddr, m0_MData, m1_MAddr, m1_MData;
  logic       m0_SCmdAccept, m1_SCmdAccept;
  logic [7:0] m0_SData, m1_SData;
  logic [1:0] m0_SResp, m1_SResp;
  logic [2:0] s_MCmd;
  logic [7:0] s_MAddr, s_MData;
  logic       s_SCmdAccept;
  logic [7:0] s_SData;
  logic [1:0] s_SResp;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ocp_master_arb2 #(.AW(8), .DW(8), .RESP_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_MCmd(m0_MCmd), .m0_MAddr(m0_MAddr), .m0_MData(m0_MData),
    .m0_SCmdAccept(m0_SCmdAccept), .m0_SData(m0_SData), .m0_SResp(m0_SResp),
    .m1_MCmd(m1_MCmd), .m1_MAddr(m1_MAddr), .m1_MData(m1_MData),
    .m1_SCmdAccept(m1_SCmdAccept), .m1_SData(m1_SData), .m1_SResp(m1_SResp),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData),
    .s_SCmdAccept(s_SCmdAccept), .s_SData(s_SData), .s_SResp(s_SResp),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;
    m0_MCmd = 3'b000; m0_MAddr = 8'h00; m0_MData = 8'h00;
    m1_MCmd = 3'b000; m1_MAddr = 8'h00; m1_MData = 8'h00;
    s_SCmdAccept = 1'b0; s_SData = 8'h00; s_SResp = 2'b00;
    tick(); tick();
    check("rst_s_MCmd", s_MCmd, 3'b000);
    check("rst_grant", grant, 2'b00);
    check("rst_s_MAddr", s_MAddr, 8'h00);
    reset_n = 1'b1;

    // 1: lone m0 write
    m0_MCmd = 3'b001; m0_MAddr = 8'h10; m0_MData = 8'h5A;
    tick();
    check("t1_s_MCmd", s_MCmd, 3'b001);
    check("t1_s_MAddr", s_MAddr, 8'h10);
    check("t1_s_MData", s_MData, 8'h5A);
    check("t1_grant", grant, 2'b01);
    s_SCmdAccept = 1'b1; #1;
    check("t1_m0_acc", m0_SCmdAccept, 1'b1);
    check("t1_m1_acc", m1_SCmdAccept, 1'b0);
    tick();
    m0_MCmd = 3'b000; s_SCmdAccept = 1'b0; #1;
    check("t1_s_MCmd_idle", s_MCmd, 3'b000);
    check("t1_grant_idle", grant, 2'b00);

    // 2: tie after reset, m0 first, responses routed to issuer
    do_reset();
    m0_MCmd = 3'b010; m0_MAddr = 8'h20;
    m1_MCmd = 3'b010; m1_MAddr = 8'h30;
    tick();
    check("t2_grant0", grant, 2'b01);
    check("t2_addr0", s_MAddr, 8'h20);
    check("t2_cmd0", s_MCmd, 3'b010);
    s_SCmdAccept = 1'b1; #1;
    check("t2_m0_acc", m0_SCmdAccept, 1'b1);
    check("t2_m1_acc", m1_SCmdAccept, 1'b0);
    tick();
    m0_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    s_SResp = 2'b01; s_SData = 8'h11; #1;
    check("t2_m0_resp", m0_SResp, 2'b01);
    check("t2_m0_data", m0_SData, 8'h11);
    check("t2_m1_resp_q", m1_SResp, 2'b00);
    tick();
    s_SResp = 2'b00; s_SData = 8'h00;
    check("t2_grant_dead", grant, 2'b00);
    tick();
    check("t2_grant1", grant, 2'b10);
    check("t2_addr1", s_MAddr, 8'h30);
    s_SCmdAccept = 1'b1; #1;
    check("t2_m1_acc", m1_SCmdAccept, 1'b1);
    tick();
    m1_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    s_SResp = 2'b01; s_SData = 8'h22; #1;
    check("t2_m1_data", m1_SData, 8'h22);
    check("t2_m1_resp", m1_SResp, 2'b01);
    check("t2_m0_resp_q", m0_SResp, 2'b00);
    tick();
    s_SResp = 2'b00; s_SData = 8'h00;

    // 3: continuous contention alternates; last grant was m1 so m0 goes first
    m0_MCmd = 3'b001; m0_MAddr = 8'h40; m0_MData = 8'hA0;
    m1_MCmd = 3'b001; m1_MAddr = 8'h41; m1_MData = 8'hA1;
    s_SCmdAccept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_addr%0d", i), s_MAddr, (i % 2 == 0) ? 8'h40 : 8'h41);
      check($sformatf("t3_m0acc%0d", i), m0_SCmdAccept, (i % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("t3_m1acc%0d", i), m1_SCmdAccept, (i % 2 == 0) ? 1'b0 : 1'b1);
      tick();
    end
    m0_MCmd = 3'b000; m1_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    tick();

    // 4: read timeout after 16 cycles, late response dropped
    m1_MCmd = 3'b010; m1_MAddr = 8'h50;
    tick();
    check("t4_grant", grant, 2'b10);
    s_SCmdAccept = 1'b1; #1;
    check("t4_m1_acc", m1_SCmdAccept, 1'b1);
    tick();
    m1_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (m1_SResp !== 2'b00 || m0_SResp !== 2'b00) bad++;
      tick();
    end
    check("t4_quiet_cycles", bad, 0);
    check("t4_to_resp", m1_SResp, 2'b11);
    check("t4_to_data", m1_SData, 8'hED);
    check("t4_to_m0", m0_SResp, 2'b00);
    tick();
    check("t4_to_one_cycle", m1_SResp, 2'b00);
    check("t4_grant_idle", grant, 2'b00);
    s_SResp = 2'b01; s_SData = 8'h99; #1;
    check("t4_late_m1", m1_SResp, 2'b00);
    check("t4_late_m0", m0_SResp, 2'b00);
    tick();
    s_SResp = 2'b00; s_SData = 8'h00;

    // 5: reset mid-read; last grant becomes m0 before reset, so a tie after reset checks last_grant reset
    m0_MCmd = 3'b010; m0_MAddr = 8'h60;
    tick();
    check("t5_grant", grant, 2'b01);
    s_SCmdAccept = 1'b1;
    tick();
    m0_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_rst_cmd", s_MCmd, 3'b000);
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_addr", s_MAddr, 8'h00);
    s_SResp = 2'b01; s_SData = 8'h77; #1;
    check("t5_drop_m0", m0_SResp, 2'b00);
    check("t5_drop_m1", m1_SResp, 2'b00);
    tick();
    s_SResp = 2'b00; s_SData = 8'h00;
    m0_MCmd = 3'b001; m0_MAddr = 8'h70;
    m1_MCmd = 3'b001; m1_MAddr = 8'h71;
    tick();
    check("t5_tie_grant", grant, 2'b01);
    check("t5_tie_addr", s_MAddr, 8'h70);
    m0_MCmd = 3'b000; m1_MCmd = 3'b000;
    s_SCmdAccept = 1'b1;
    tick();
    s_SCmdAccept = 1'b0;
    tick();

    // 6: reserved command code is never forwarded
    m1_MCmd = 3'b011; m1_MAddr = 8'h80;
    s_SCmdAccept = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_MCmd !== 3'b000 || m1_SCmdAccept !== 1'b0 || grant !== 2'b00) bad++;
    end
    check("t6_bad_cycles", bad, 0);
    check("t6_s_MCmd", s_MCmd, 3'b000);
    m1_MCmd = 3'b000; s_SCmdAccept = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
